// File: rtl/pdpu_pkg.sv
// pdpu_pkg
//   Shared types and helpers for the PDPU datapath stages.
//   - acc_state_e : state encoding of the accumulate/hold FSM in csa_accum_stage
//   - clog2       : ceiling log2, usable in parameter/localparam expressions
package pdpu_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } acc_state_e;

  // Number of bits needed to encode values 0 .. value-1 (value >= 2).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/csa_accum_stage_cpa_sext.sv
// cpa_sext
//   Resolves a redundant (sum, carry) pair with a carry-propagate add and
//   sign-extends the result. The add is truncated to WIDTH_I bits first:
//   the compression tree output is only meaningful modulo 2^WIDTH_I, so any
//   carry out of the top bit must be dropped before the sign is taken.
// Ports
//   i_sum   in   WIDTH_I    CSA sum vector
//   i_carry in   WIDTH_I    CSA carry vector (already aligned)
//   o_val   out  WIDTH_ACC  sext((i_sum + i_carry) mod 2^WIDTH_I)
module cpa_sext #(
  parameter int WIDTH_I   = 16,
  parameter int WIDTH_ACC = 24
) (
  input  logic [WIDTH_I-1:0]   i_sum,
  input  logic [WIDTH_I-1:0]   i_carry,
  output logic [WIDTH_ACC-1:0] o_val
);

  logic [WIDTH_I-1:0] w_res;

  assign w_res = i_sum + i_carry;
  assign o_val = WIDTH_ACC'($signed(w_res));

endmodule

// File: rtl/csa_accum_stage.sv
// csa_accum_stage
//   Resolves CSA (sum, carry) beats and accumulates them over a burst,
//   emitting one signed WIDTH_ACC result per burst through a valid/ready
//   output. Two pipeline steps: stage 1 registers the resolved beat, stage 2
//   adds it into the accumulator. A burst ends on last_i or is cut at
//   MAX_BEATS beats (flagged by len_err_o).
// Ports
//   clk_i        in   1          clock, rising edge
//   rst_i        in   1          synchronous reset, active-high
//   in_valid_i   in   1          sum_i/carry_i/last_i valid
//   in_ready_o   out  1          stage can accept a beat
//   sum_i        in   WIDTH_I    CSA sum vector
//   carry_i      in   WIDTH_I    CSA carry vector
//   last_i       in   1          final beat of burst
//   out_valid_o  out  1          result outputs valid
//   out_ready_i  in   1          consumer accepts result
//   acc_o        out  WIDTH_ACC  accumulated signed result
//   beats_o      out  CW         beats in the burst (1..MAX_BEATS)
//   ovf_o        out  1          signed overflow seen during the burst (sticky)
//   len_err_o    out  1          burst cut at MAX_BEATS without last_i
//
// FSM states
//   state | meaning
//   ACC   | accumulating beats; no result pending
//   HOLD  | result presented on outputs, waiting for out_ready_i
module csa_accum_stage
  import pdpu_pkg::*;
#(
  parameter int WIDTH_I   = 16,
  parameter int WIDTH_ACC = 24,
  parameter int MAX_BEATS = 8,
  localparam int CW       = clog2(MAX_BEATS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH_I-1:0]   sum_i,
  input  logic [WIDTH_I-1:0]   carry_i,
  input  logic                 last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH_ACC-1:0] acc_o,
  output logic [CW-1:0]        beats_o,
  output logic                 ovf_o,
  output logic                 len_err_o
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BEATS);

  acc_state_e r_state;
  acc_state_e w_state_nxt;

  // stage 1
  logic                 r_s1_valid;
  logic                 r_s1_last;
  logic                 r_s1_lerr;
  logic [WIDTH_ACC-1:0] r_s1_val;
  logic [CW-1:0]        r_in_cnt;

  // stage 2 / result
  logic [WIDTH_ACC-1:0] r_acc;
  logic [CW-1:0]        r_beat_cnt;
  logic [CW-1:0]        r_beats;
  logic                 r_ovf;
  logic                 r_lerr;

  logic                 w_accept;
  logic [WIDTH_ACC-1:0] w_cpa;
  logic [CW-1:0]        w_in_cnt_inc;
  logic                 w_in_force;
  logic                 w_in_last;

  logic                 w_s2_fire;
  logic [WIDTH_ACC-1:0] w_base;
  logic [WIDTH_ACC-1:0] w_sum;
  logic                 w_step_ovf;
  logic [CW-1:0]        w_beat_cnt_inc;
  logic                 w_release;

  cpa_sext #(
    .WIDTH_I   (WIDTH_I),
    .WIDTH_ACC (WIDTH_ACC)
  ) u_cpa_sext (
    .i_sum   (sum_i),
    .i_carry (carry_i),
    .o_val   (w_cpa)
  );

  // Stage 2 lags acceptance by a cycle, so the burst-length limit is judged
  // on a separate count of accepted beats rather than on r_beat_cnt.
  assign w_in_cnt_inc = r_in_cnt + CW'(1);
  assign w_in_force   = (w_in_cnt_inc == MAX_CNT);
  assign w_in_last    = last_i | w_in_force;

  assign out_valid_o  = (r_state == HOLD);
  assign in_ready_o   = !out_valid_o && !(r_s1_valid && r_s1_last);
  assign w_accept     = in_valid_i && in_ready_o;

  assign w_s2_fire      = r_s1_valid && (r_state == ACC);
  assign w_release      = (r_state == HOLD) && out_ready_i;
  assign w_beat_cnt_inc = r_beat_cnt + CW'(1);

  // First beat of a burst starts from zero so the previous result can stay
  // on acc_o until the new burst actually begins accumulating.
  assign w_base     = (r_beat_cnt == '0) ? '0 : r_acc;
  assign w_sum      = w_base + r_s1_val;
  assign w_step_ovf = (w_base[WIDTH_ACC-1] == r_s1_val[WIDTH_ACC-1]) &&
                      (w_sum[WIDTH_ACC-1] != w_base[WIDTH_ACC-1]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACC:     if (r_s1_valid && r_s1_last) w_state_nxt = HOLD;
      HOLD:    if (out_ready_i)             w_state_nxt = ACC;
      default:                              w_state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_lerr  <= 1'b0;
      r_s1_val   <= '0;
      r_in_cnt   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_val  <= w_cpa;
        r_s1_last <= w_in_last;
        // last_i arriving exactly on the limit is a normal termination
        r_s1_lerr <= w_in_force && !last_i;
        r_in_cnt  <= w_in_last ? '0 : w_in_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc      <= '0;
      r_beat_cnt <= '0;
      r_beats    <= '0;
      r_ovf      <= 1'b0;
      r_lerr     <= 1'b0;
    end else if (w_s2_fire) begin
      r_acc <= w_sum;
      r_ovf <= r_ovf | w_step_ovf;
      if (r_s1_last) begin
        r_beats    <= w_beat_cnt_inc;
        r_lerr     <= r_s1_lerr;
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= w_beat_cnt_inc;
      end
    end else if (w_release) begin
      r_ovf <= 1'b0;
    end
  end

  assign acc_o     = r_acc;
  assign beats_o   = r_beats;
  assign ovf_o     = r_ovf;
  assign len_err_o = r_lerr;

endmodule
